// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the Memoria32 port arbiter and its helpers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    RESP
  } arb_state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_DM = 1'b1
  } arb_src_t;

  localparam int unsigned MEM_WORD_W  = 32;
  localparam int unsigned BEAT_STRIDE = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, response and memory-port signals of the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic              dm_dbl;
  logic [ADDR_W-1:0] dm_addr;
  logic [63:0]       dm_wdata;
  logic              dm_gnt;
  logic              dm_done;
  logic [63:0]       dm_rdata;

  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              mem_wr;
  logic [31:0]       mem_rdata;

  // Requesters plus the memory itself.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_dbl, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_done, dm_rdata,
    input  mem_raddr, mem_waddr, mem_wdata, mem_wr
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_dbl, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_done, dm_rdata,
    output mem_raddr, mem_waddr, mem_wdata, mem_wr
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; req[0] is IF, req[1] is DM.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  arb_src_t   last,
  output arb_src_t   winner
);

  always_comb begin
    winner = SRC_IF;
    if (req == 2'b11) begin
      winner = (last == SRC_IF) ? SRC_DM : SRC_IF;
    end else if (req[1]) begin
      winner = SRC_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single 32-bit memory port between instruction fetch and data memory,
// splitting 64-bit data accesses into two consecutive word beats.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned ADDR_W  = 64
) (
  input  logic              CLK,
  input  logic              RST,
  mem_port_arbiter_if.slave bus
);

  arb_state_t            state_q, state_d;
  arb_src_t              last_q, last_d, src_q, src_d, winner;
  logic                  we_q, we_d, dbl_q, dbl_d, beat_q, beat_d;
  logic [2:0]            lat_q, lat_d;
  logic [ADDR_W-1:0]     addr_q, addr_d, beat_addr;
  logic [63:0]           wdata_q, wdata_d, dm_rdata_q, dm_rdata_d;
  logic [MEM_WORD_W-1:0] lo_q, lo_d, if_rdata_q, if_rdata_d;
  logic                  any_req, last_beat, beat_end;

  rr_pick2 u_pick (
    .req    ({bus.dm_req, bus.if_req}),
    .last   (last_q),
    .winner (winner)
  );

  assign any_req   = bus.if_req | bus.dm_req;
  assign beat_addr = beat_q ? addr_q + ADDR_W'(BEAT_STRIDE) : addr_q;
  assign last_beat = (beat_q == dbl_q);
  assign beat_end  = we_q | (lat_q == 3'(MEM_LAT));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      last_q     <= SRC_DM;
      src_q      <= SRC_IF;
      we_q       <= 1'b0;
      dbl_q      <= 1'b0;
      beat_q     <= 1'b0;
      lat_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lo_q       <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      src_q      <= src_d;
      we_q       <= we_d;
      dbl_q      <= dbl_d;
      beat_q     <= beat_d;
      lat_q      <= lat_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lo_q       <= lo_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    src_d      = src_q;
    we_d       = we_q;
    dbl_d      = dbl_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lo_d       = lo_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BEAT;
          last_d  = winner;
          src_d   = winner;
          beat_d  = 1'b0;
          lat_d   = '0;
          if (winner == SRC_IF) begin
            addr_d  = bus.if_addr;
            we_d    = 1'b0;
            dbl_d   = 1'b0;
            wdata_d = '0;
          end else begin
            addr_d  = bus.dm_addr;
            we_d    = bus.dm_we;
            dbl_d   = bus.dm_dbl;
            wdata_d = bus.dm_wdata;
          end
        end
      end
      BEAT: begin
        if (beat_end) begin
          lat_d = '0;
          // Read data is captured on the final beat edge so it is valid during RESP.
          if (!we_q) begin
            if (!beat_q) lo_d = bus.mem_rdata;
            if (last_beat) begin
              if (src_q == SRC_IF) if_rdata_d = bus.mem_rdata;
              else dm_rdata_d = dbl_q ? {bus.mem_rdata, lo_q} : {32'b0, bus.mem_rdata};
            end
          end
          if (last_beat) state_d = RESP;
          else beat_d = 1'b1;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.if_gnt    = 1'b0;
    bus.dm_gnt    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.dm_done   = 1'b0;
    bus.if_rdata  = if_rdata_q;
    bus.dm_rdata  = dm_rdata_q;
    bus.mem_raddr = '0;
    bus.mem_waddr = '0;
    bus.mem_wdata = '0;
    bus.mem_wr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!RST && any_req) begin
          bus.if_gnt = (winner == SRC_IF);
          bus.dm_gnt = (winner == SRC_DM);
        end
      end
      BEAT: begin
        bus.mem_raddr = beat_addr;
        bus.mem_waddr = beat_addr;
        bus.mem_wr    = we_q;
        if (we_q) bus.mem_wdata = beat_q ? wdata_q[63:32] : wdata_q[31:0];
      end
      RESP: begin
        if (!RST) begin
          bus.if_rvalid = (src_q == SRC_IF);
          bus.dm_done   = (src_q == SRC_DM);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random two-requester traffic
// checked against a transaction-level model with its own memory image.
module tb_mem_port_arbiter;

  localparam int unsigned LAT = 1;

  logic clk;
  logic rst;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_err = 0;

  mem_port_arbiter_if #(.ADDR_W(64)) bus ();

  mem_port_arbiter #(.MEM_LAT(LAT), .ADDR_W(64)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Memory image written by the DUT, and the reference image written by the model.
  logic [31:0] mem     [logic [63:0]];
  logic [31:0] ref_mem [logic [63:0]];

  function automatic logic [31:0] mem_default(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : mem_default(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
  endfunction

  task automatic preload(input logic [63:0] a, input logic [31:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  // Memory: data valid only once the read address has been stable for LAT cycles.
  logic [63:0] prev_raddr = '0;
  int unsigned stable = 0;
  initial begin
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_wr) mem[bus.mem_waddr] = bus.mem_wdata;
      if (bus.mem_raddr == prev_raddr) begin
        if (stable < 1000) stable++;
      end else stable = 0;
      prev_raddr    = bus.mem_raddr;
      bus.mem_rdata = (stable >= LAT) ? mem_rd(bus.mem_raddr) : 32'hDEAD_DEAD;
    end
  end

  // Transaction-level reference model.
  bit          act = 1'b0;
  bit          ref_last_dm = 1'b1;
  int unsigned g = 0;
  bit          t_if, t_we, t_dbl;
  logic [63:0] t_addr, t_wdata, t_exp;
  logic [31:0] ref_if_rdata = '0;
  logic [63:0] ref_dm_rdata = '0;
  int unsigned n_if_gnt = 0, n_dm_gnt = 0, n_rvalid = 0, n_done = 0, n_wr = 0;
  bit          gnt_log[$];
  bit          if_gnt_seen = 1'b0, dm_gnt_seen = 1'b0;

  task automatic model_step();
    bit          r, win_if, resp;
    bit          exp_ig, exp_dg, exp_rv, exp_dn, exp_wr;
    logic [63:0] exp_addr;
    logic [31:0] exp_wd;
    int unsigned k, nb, bl, beat;
    r = rst;
    {exp_ig, exp_dg, exp_rv, exp_dn, exp_wr, resp} = '0;
    exp_addr = '0;
    exp_wd   = '0;
    if (!act) begin
      if ((bus.if_req || bus.dm_req) && !r) begin
        win_if = bus.if_req && (!bus.dm_req || ref_last_dm);
        act = 1'b1;
        g   = cyc;
        t_if = win_if;
        if (win_if) begin
          t_we = 1'b0; t_dbl = 1'b0; t_addr = bus.if_addr; t_wdata = '0;
        end else begin
          t_we = bus.dm_we; t_dbl = bus.dm_dbl; t_addr = bus.dm_addr; t_wdata = bus.dm_wdata;
        end
        t_exp = t_dbl ? {ref_rd(t_addr + 64'd4), ref_rd(t_addr)} : {32'b0, ref_rd(t_addr)};
        ref_last_dm = !win_if;
        exp_ig = win_if;
        exp_dg = !win_if;
      end
    end else begin
      k  = cyc - g;
      nb = t_dbl ? 2 : 1;
      bl = t_we ? 1 : LAT + 1;
      if (k <= nb * bl) begin
        beat     = (k - 1) / bl;
        exp_addr = t_addr + 64'(4 * beat);
        exp_wr   = t_we;
        if (t_we) exp_wd = (beat != 0) ? t_wdata[63:32] : t_wdata[31:0];
      end else begin
        resp   = 1'b1;
        exp_rv = !r && t_if;
        exp_dn = !r && !t_if;
      end
    end
    if (resp && t_if) ref_if_rdata = t_exp[31:0];
    if (resp && !t_if && !t_we) ref_dm_rdata = t_exp;

    check("if_gnt", 64'(bus.if_gnt), 64'(exp_ig));
    check("dm_gnt", 64'(bus.dm_gnt), 64'(exp_dg));
    check("if_rvalid", 64'(bus.if_rvalid), 64'(exp_rv));
    check("dm_done", 64'(bus.dm_done), 64'(exp_dn));
    check("mem_wr", 64'(bus.mem_wr), 64'(exp_wr));
    check("mem_raddr", bus.mem_raddr, exp_addr);
    check("mem_waddr", bus.mem_waddr, exp_addr);
    if (exp_wr) begin
      check("mem_wdata", 64'(bus.mem_wdata), 64'(exp_wd));
      ref_mem[exp_addr] = exp_wd;
    end
    if (!r) begin
      check("if_rdata", 64'(bus.if_rdata), 64'(ref_if_rdata));
      check("dm_rdata", bus.dm_rdata, ref_dm_rdata);
    end
    if (resp) act = 1'b0;
    if (r) begin
      act = 1'b0;
      ref_last_dm  = 1'b1;
      ref_if_rdata = '0;
      ref_dm_rdata = '0;
    end

    if (bus.if_gnt) begin n_if_gnt++; gnt_log.push_back(1'b0); end
    if (bus.dm_gnt) begin n_dm_gnt++; gnt_log.push_back(1'b1); end
    if (bus.if_rvalid) n_rvalid++;
    if (bus.dm_done) n_done++;
    if (bus.mem_wr) n_wr++;
    if_gnt_seen = bus.if_gnt;
    dm_gnt_seen = bus.dm_gnt;
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  // which: 0 if_gnt, 1 dm_gnt, 2 if_rvalid, 3 dm_done
  task automatic wait_for(input int which, input int unsigned limit, output bit seen);
    seen = 1'b0;
    for (int unsigned i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      case (which)
        0: seen = bus.if_gnt;
        1: seen = bus.dm_gnt;
        2: seen = bus.if_rvalid;
        default: seen = bus.dm_done;
      endcase
    end
  endtask

  task automatic issue(input bit is_if, input bit we, input bit dbl, input logic [63:0] addr,
                       input logic [63:0] wdata, output int unsigned lat);
    bit seen;
    int unsigned gc;
    lat = 0;
    @(posedge clk); #1;
    if (is_if) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end else begin
      bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_dbl = dbl; bus.dm_addr = addr; bus.dm_wdata = wdata;
    end
    wait_for(is_if ? 0 : 1, 50, seen);
    gc = cyc;
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    if (!seen) begin
      check("gnt_timeout", 64'd0, 64'd1);
      return;
    end
    wait_for(is_if ? 2 : 3, 50, seen);
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    else lat = cyc - gc;
  endtask

  function automatic logic [63:0] rand_addr();
    if ($urandom_range(7) == 0) return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(3)) * 4;
    return 64'h1000 + 64'($urandom_range(31)) * 4;
  endfunction

  task automatic drv_if(input int unsigned ncyc);
    for (int unsigned i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (bus.if_req && !if_gnt_seen) begin
        if ($urandom_range(15) == 0) bus.if_req = 1'b0;
      end else begin
        bus.if_req = 1'($urandom_range(1));
        if (bus.if_req) bus.if_addr = rand_addr();
      end
    end
    bus.if_req = 1'b0;
  endtask

  task automatic drv_dm(input int unsigned ncyc);
    for (int unsigned i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (bus.dm_req && !dm_gnt_seen) begin
        if ($urandom_range(15) == 0) bus.dm_req = 1'b0;
      end else begin
        bus.dm_req = 1'($urandom_range(1));
        if (bus.dm_req) begin
          bus.dm_we    = 1'($urandom_range(1));
          bus.dm_dbl   = 1'($urandom_range(1));
          bus.dm_addr  = rand_addr();
          bus.dm_wdata = {$urandom, $urandom};
        end
      end
    end
    bus.dm_req = 1'b0;
  endtask

  initial begin
    int unsigned lat, w0, d0, s, rv0, dn0;
    bit seen;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_dbl = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 64'({bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_done, bus.mem_wr}), 64'd0);
    check("rst_addr", bus.mem_raddr | bus.mem_waddr, 64'd0);
    check("rst_rdata", bus.dm_rdata | 64'(bus.if_rdata) | 64'(bus.mem_wdata), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // IF fetch
    preload(64'h40, 32'h00A0_0093);
    issue(1'b1, 1'b0, 1'b0, 64'h40, '0, lat);
    check("if_lat", 64'(lat), 64'(2 + LAT));
    check("if_data", 64'(bus.if_rdata), 64'h00A0_0093);

    // 64-bit load
    preload(64'h100, 32'h1111_1111);
    preload(64'h104, 32'h2222_2222);
    issue(1'b0, 1'b0, 1'b1, 64'h100, '0, lat);
    check("ld64_lat", 64'(lat), 64'(3 + 2 * LAT));
    check("ld64_data", bus.dm_rdata, 64'h2222_2222_1111_1111);

    // 32-bit load, zero-extended
    issue(1'b0, 1'b0, 1'b0, 64'h104, '0, lat);
    check("ld32_lat", 64'(lat), 64'(2 + LAT));
    check("ld32_data", bus.dm_rdata, 64'h0000_0000_2222_2222);

    // 64-bit store
    w0 = n_wr;
    issue(1'b0, 1'b1, 1'b1, 64'h200, 64'hDEAD_BEEF_CAFE_F00D, lat);
    check("st64_lat", 64'(lat), 64'd3);
    check("st64_wrs", 64'(n_wr - w0), 64'd2);
    check("st64_lo", 64'(mem_rd(64'h200)), 64'hCAFE_F00D);
    check("st64_hi", 64'(mem_rd(64'h204)), 64'hDEAD_BEEF);

    // 32-bit store
    issue(1'b0, 1'b1, 1'b0, 64'h208, 64'h1234_5678_9ABC_DEF0, lat);
    check("st32_lat", 64'(lat), 64'd2);
    check("st32_mem", 64'(mem_rd(64'h208)), 64'h9ABC_DEF0);

    // Address wrap on beat 1
    preload(64'hFFFF_FFFF_FFFF_FFFC, 32'hA5A5_0001);
    preload(64'h0, 32'h5A5A_0002);
    issue(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, '0, lat);
    check("wrap_data", bus.dm_rdata, 64'h5A5A_0002_A5A5_0001);

    // Reset in first BEAT cycle of a 64-bit store
    @(posedge clk); #1;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_dbl = 1'b1;
    bus.dm_addr = 64'h300; bus.dm_wdata = 64'h7777_6666_5555_4444;
    wait_for(1, 50, seen);
    if (!seen) check("rst_st_gnt", 64'd0, 64'd1);
    w0 = n_wr;
    d0 = n_done;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_wrs", 64'(n_wr - w0), 64'd1);
    check("rst_mid_done", 64'(n_done - d0), 64'd0);
    check("rst_mid_out", 64'({bus.if_gnt, bus.dm_gnt, bus.dm_done, bus.mem_wr}), 64'd0);
    check("rst_mid_addr", bus.mem_raddr | bus.mem_waddr | bus.dm_rdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_for(1, 5, seen);
    check("rst_regrant", 64'(seen), 64'd1);
    @(posedge clk); #1;
    bus.dm_req = 1'b0;
    wait_for(3, 50, seen);
    check("rst_redone", 64'(seen), 64'd1);
    check("rst_st_mem", {mem_rd(64'h304), mem_rd(64'h300)}, 64'h7777_6666_5555_4444);

    // Both requests held continuously from reset
    @(posedge clk); #1;
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 64'h80;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_dbl = 1'b0; bus.dm_addr = 64'h100;
    @(posedge clk); #1;
    rst = 1'b0;
    s = gnt_log.size();
    rv0 = n_rvalid;
    dn0 = n_done;
    for (int i = 0; i < 300 && gnt_log.size() - s < 8; i++) @(negedge clk);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    repeat (20) @(negedge clk);
    check("rr_grants", 64'(gnt_log.size() - s), 64'd8);
    for (int unsigned i = 0; i < 8; i++) begin
      if (s + i < gnt_log.size()) check("rr_order", 64'(gnt_log[s + i]), 64'(i % 2));
    end
    check("rr_rvalid", 64'(n_rvalid - rv0), 64'd4);
    check("rr_done", 64'(n_done - dn0), 64'd4);

    // Random two-requester traffic
    fork
      drv_if(3000);
      drv_dm(3000);
    join
    repeat (30) @(negedge clk);
    check("rand_if_pairs", 64'(n_rvalid), 64'(n_if_gnt));
    check("rand_dm_pairs", 64'(n_done), 64'(n_dm_gnt - 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single 32-bit `Memoria32` port of the multicycle RISC-V core between two requesters: instruction fetch (IF, word reads) and data memory (DM, 32- or 64-bit loads and stores). A 64-bit DM access is split into two consecutive 32-bit beats. The block sits between the control state machine/datapath and the memory, and owns `raddress`, `waddress`, `Datain` and `Wr`.

## Interface
- `MEM_LAT`, 1: memory read latency in cycles, from address presented to `Dataout` valid; legal range 1..4.
- `ADDR_W`, 64: address width.

- `CLK`  in  1  clock; everything updates on the rising edge.
- `RST`  in  1  reset; one clock; reset is synchronous and active-high.
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_gnt`  out  1  one-cycle acceptance pulse.
- `if_rvalid`  out  1  one-cycle pulse; `if_rdata` valid in the same cycle.
- `if_rdata`  out  32  fetched instruction word.
- `dm_req`  in  1  data request; held with its payload stable until `dm_gnt`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_dbl`  in  1  1 = 64-bit access, 0 = 32-bit access.
- `dm_addr`  in  ADDR_W  data address.
- `dm_wdata`  in  64  store data; bits [31:0] only when `dm_dbl` = 0.
- `dm_gnt`  out  1  one-cycle acceptance pulse.
- `dm_done`  out  1  one-cycle completion pulse, for both loads and stores.
- `dm_rdata`  out  64  load data, valid with `dm_done` on loads; a 32-bit load is zero-extended.
- `mem_raddr`, `mem_waddr`  out  ADDR_W  both driven with the current beat address.
- `mem_wdata`  out  32  current store word.
- `mem_wr`  out  1  memory write strobe.
- `mem_rdata`  in  32  memory read data.

## Operation
- States: IDLE, BEAT, RESP.
- **IDLE**
  - If any request is present, pick a winner, assert its `gnt` combinationally in this cycle, and latch its payload at the edge. Next state is BEAT with beat index 0.
  - Arbitration is round-robin on a `last` flag. With both requests present, the requester not granted last wins. A single request wins outright.
  - `last` resets to DM, so IF wins the first contention after reset.
- **BEAT**
  - The beat address is the latched address + 4 × beat index, computed modulo 2^64. For example, 0xFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
  - Read beat:
    - Hold the address for MEM_LAT+1 cycles.
    - Sample `mem_rdata` at the edge ending the last of those cycles.
    - Beat 0 goes to data bits [31:0]; beat 1 goes to bits [63:32].
  - Write beat:
    - Lasts one cycle with `mem_wr` = 1.
    - `mem_wdata` = `dm_wdata[31:0]` for beat 0 and `dm_wdata[63:32]` for beat 1.
  - After the last beat, go to RESP. The last beat is beat 0 for IF or a 32-bit access, and beat 1 for a 64-bit access.
- **RESP**: pulse `if_rvalid` or `dm_done` for the granted requester, then go to IDLE.
- A request dropped before its grant has no effect.
- A request still high in IDLE after completion is treated as a new access.
- Address low bits are forwarded unmodified; alignment checking is not done here.

## Timing
- Reset values:
  - Every output is 0.
  - The state is IDLE and `last` = DM.
  - The latched payload and read data are cleared to 0.
- Cycle 0 is the IDLE cycle with the grant.
  - IF read, or 32-bit load: RESP in cycle 2+MEM_LAT. With MEM_LAT = 1, that is cycle 3.
  - 64-bit load: RESP in cycle 3+2·MEM_LAT.
  - 32-bit store: the write is in cycle 1 and `dm_done` in cycle 2.
  - 64-bit store: writes in cycles 1–2 and `dm_done` in cycle 3.
- The earliest next grant is the cycle after RESP.
- `if_rdata` and `dm_rdata` hold their value until the next completion of the same requester.
- In IDLE and RESP, `mem_wr` = 0 and `mem_*addr` = 0.
- `RST` asserted in any state:
  - IDLE is entered at the next edge.
  - No `done`, `rvalid` or `gnt` pulse occurs.
  - `mem_wr` is 0 from that edge.
  - An already-written first beat of a 64-bit store is not rolled back.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum `arb_state_t` {IDLE, BEAT, RESP};
  - the requester enum `arb_src_t` {SRC_IF, SRC_DM};
  - the constants `MEM_WORD_W` = 32 and `BEAT_STRIDE` = 4.
- One sub-module, `rr_pick2`: a combinational two-way round-robin picker with inputs req[1:0] and last, and a winner output. It is reused later for bus arbitration.

## Test plan
- MEM_LAT = 1, IF only, `if_addr` = 0x40, memory[0x40] = 0x00A00093 → `if_gnt` in cycle 0, `if_rvalid` in cycle 3 with `if_rdata` = 0x00A00093.
- 64-bit load at 0x100, mem[0x100] = 0x11111111, mem[0x104] = 0x22222222 → `dm_done` in cycle 5 with `dm_rdata` = 0x22222222_11111111.
- 64-bit store of 0xDEADBEEF_CAFEF00D at 0x200 → `mem_wr` in cycles 1–2 at 0x200 then 0x204, with data 0xCAFEF00D then 0xDEADBEEF; `dm_done` in cycle 3.
- `if_req` and `dm_req` both held continuously from reset → grants alternate IF, DM, IF, DM, with no lost or duplicated `done`/`rvalid` pulses.
- 64-bit load at 0xFFFF_FFFF_FFFF_FFFC → the beat 1 address is 0x0.
- `RST` pulsed in the first BEAT cycle of a 64-bit store → exactly one `mem_wr` cycle, no `dm_done`, all outputs 0 at the next edge; `dm_req` is re-granted after `RST` drops.
